clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Run-time controller for the team's counter-based clock divider: it sequences start/stop of a divided clock and applies new divisors without glitches. It produces a one-cycle `tick` enable at the end of each period and a near-50% `clk_out`. New divisors are loaded through a valid/ready handshake and take effect only at a period boundary. It sits between control logic (switches, FSMs, host registers) and the blocks that consume slow ticks, such as display scanners and game-state timers.

## Interface
- `WIDTH`, 28: counter and divisor width in bits.
- `DEFAULT_DIV`, 28'd50000000: divisor loaded at reset (1 Hz from 50 MHz).

- `clk_in`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; request counting.
- `stop`  in  1  level; request halt at the end of the current period. Dominates `start`.
- `div_valid`  in  1  new divisor offered.
- `div_data`  in  WIDTH  offered divisor.
- `div_ready`  out  1  controller can accept a divisor.
- `err_clr`  in  1  clears `err`.
- `tick`  out  1  one-cycle pulse in the last cycle of each period.
- `clk_out`  out  1  divided clock.
- `running`  out  1  high in RUN and DRAIN.
- `div_active`  out  WIDTH  divisor currently in use.
- `err`  out  1  sticky; an illegal divisor was offered.

## Operation
- FSM states:
  - IDLE: counter held at 0.
  - RUN: counting.
  - DRAIN: counting; stop is pending.
- IDLE transitions:
  - `start`=1 and `stop`=0 → RUN. Counter is 0 in the first RUN cycle.
  - Otherwise stay in IDLE.
- RUN transitions:
  - `stop`=1 → DRAIN.
  - Otherwise stay in RUN.
- DRAIN transitions:
  - Boundary cycle → IDLE.
  - `start`=1 and `stop`=0 before the boundary → RUN. The count is not disturbed.
- Counter, in RUN and DRAIN:
  - Counts 0 … D−1, where D = `div_active`, then wraps to 0.
  - Boundary cycle = the cycle where counter = D−1.
- `tick` = `running` AND counter = D−1. Decoded from registers only.
- `clk_out` = `running` AND counter < floor(D/2).
  - Odd D: high for floor(D/2) cycles, low for ceil(D/2) cycles.
  - In IDLE, `clk_out` is 0.
- Divisor handshake: a transfer happens when `div_valid` AND `div_ready`.
  - Legal divisor is ≥ 2.
  - Illegal divisor (0 or 1): the transfer completes, the value is discarded, and `err` is set to 1. `div_active` and the pending value are unchanged.
  - Legal divisor in IDLE: `div_active` takes the value in the next cycle. `div_ready` stays 1.
  - Legal divisor in RUN or DRAIN: the value is stored in the pending register, the pending flag is set, and `div_ready` drops to 0 in the next cycle.
  - At the next boundary cycle, the pending value is loaded into `div_active` and the counter wraps to 0. The pending flag clears and `div_ready` returns to 1 in the following cycle.
- `err`:
  - Sticky until `err_clr`=1, which clears it in the next cycle.
  - If an illegal transfer and `err_clr` occur in the same cycle, `err` is set.

## Timing
- Reset values, applied immediately on assertion:
  - state = IDLE, counter = 0, `div_active` = `DEFAULT_DIV`, pending flag = 0.
  - `div_ready` = 1, `tick` = 0, `clk_out` = 0, `running` = 0, `err` = 0.
- Reset during RUN or DRAIN discards the count and any pending divisor. No `tick` is emitted.
- Start latency: `start` sampled at edge k → `running` = 1 and `clk_out` = 1 from edge k.
  - The first `tick` is in cycle k+D−1.
  - Ticks then repeat every D cycles.
- Stop: the last `tick` is the boundary at or after `stop` is sampled. `running` = 0 in the next cycle.
- Stop requested in the boundary cycle itself: that boundary is the final one.
- Handshake accepted in the same cycle as a boundary: the value is pending and is applied at the following boundary, not the current one.
- `div_ready` is low for at most one period plus 1 cycle.
- Counter arithmetic is unsigned WIDTH-bit. D ≤ 2^WIDTH−1, so the counter never overflows.

## Test plan
- Reset, then `start` with D=4 (default overridden in IDLE): `clk_out` pattern 1,1,0,0 repeating. `tick` in cycles 3, 7, 11 after start.
- Load D=6 in RUN while D=4: `div_ready` is 0 until the next boundary. Old period completes, then the first D=6 period gives `tick` 6 cycles later. `clk_out` is high 3 cycles, low 3 cycles.
- Offer D=1, then D=0: both accepted, `err`=1, `div_active` unchanged. `err_clr` pulse → `err`=0.
- `stop` at counter=1 with D=5: `tick` at counter=4, then IDLE. `running`=0 and `clk_out`=0 from the next cycle.
- `stop` then `start` before the boundary (DRAIN→RUN): ticks continue every D cycles with no gap. Odd D=5 gives `clk_out` high 2 cycles, low 3 cycles.
- Assert `reset` mid-period with a divisor pending: all outputs immediately at reset values, and `div_active` = `DEFAULT_DIV`.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// Run-time controller for the counter-based clock divider: start/stop sequencing,
// glitch-free divisor changes at period boundaries, tick and near-50% clock outputs.
module clkdiv_ctrl #(
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd50000000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_data,
  output logic             div_ready,
  input  logic             err_clr,
  output logic             tick,
  output logic             clk_out,
  output logic             running,
  output logic [WIDTH-1:0] div_active,
  output logic             err
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] div_s;
  logic [WIDTH-1:0] pend_val_r, pend_val_s;
  logic             pend_r, pend_s;
  logic             err_s;
  logic             run_now_s, boundary_s, xfer_s, legal_s;
  logic             run_next_s, tick_s, clk_s;

  // Decode current-cycle conditions from registered state.
  always_comb begin
    run_now_s  = (state_r != ST_IDLE);
    boundary_s = run_now_s && (cnt_r == (div_active - ONE_C));
    xfer_s     = div_valid && div_ready;
    legal_s    = (div_data > ONE_C);
  end

  // Next-state logic; a stop seen on the boundary itself ends the run there.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) state_s = ST_RUN;
        else                state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop && boundary_s) state_s = ST_IDLE;
        else if (stop)          state_s = ST_DRAIN;
        else                    state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (boundary_s)          state_s = ST_IDLE;
        else if (start && !stop) state_s = ST_RUN;
        else                     state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Counter, divisor staging and error flag.
  always_comb begin
    cnt_s      = ZERO_C;
    div_s      = div_active;
    pend_s     = pend_r;
    pend_val_s = pend_val_r;
    err_s      = err;
    if (run_now_s && !boundary_s) cnt_s = cnt_r + ONE_C;
    else                          cnt_s = ZERO_C;
    // A pending divisor holds div_ready low, so it never collides with a new transfer.
    if (boundary_s && pend_r) begin
      div_s  = pend_val_r;
      pend_s = 1'b0;
    end else if (xfer_s && legal_s && !run_now_s) begin
      div_s = div_data;
    end else if (xfer_s && legal_s) begin
      pend_s     = 1'b1;
      pend_val_s = div_data;
    end else begin
      pend_s = pend_r;
    end
    if (xfer_s && !legal_s) err_s = 1'b1;
    else if (err_clr)       err_s = 1'b0;
    else                    err_s = err;
  end

  // Outputs are decoded from next-cycle values so they leave the block registered.
  always_comb begin
    run_next_s = (state_s != ST_IDLE);
    tick_s     = run_next_s && (cnt_s == (div_s - ONE_C));
    clk_s      = run_next_s && (cnt_s < {1'b0, div_s[WIDTH-1:1]});
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= ZERO_C;
      div_active <= DEFAULT_DIV;
      pend_r     <= 1'b0;
      pend_val_r <= ZERO_C;
      err        <= 1'b0;
      div_ready  <= 1'b1;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
      running    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_active <= div_s;
      pend_r     <= pend_s;
      pend_val_r <= pend_val_s;
      err        <= err_s;
      div_ready  <= !pend_s;
      tick       <= tick_s;
      clk_out    <= clk_s;
      running    <= run_next_s;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl; expectations come from period arithmetic
// (cycle index modulo divisor) rather than a copy of the controller.
module tb_clkdiv_ctrl;

  logic        clk_in = 1'b0;
  logic        reset, start, stop, div_valid, err_clr;
  logic [27:0] div_data;
  logic        div_ready, tick, clk_out, running, err;
  logic [27:0] div_active;
  int          errors = 0;
  int          checks = 0;

  clkdiv_ctrl dut (
    .clk_in(clk_in), .reset(reset), .start(start), .stop(stop),
    .div_valid(div_valid), .div_data(div_data), .div_ready(div_ready),
    .err_clr(err_clr), .tick(tick), .clk_out(clk_out), .running(running),
    .div_active(div_active), .err(err)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    div_valid = 1'b0; div_data = 28'd0; err_clr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic load_idle(input int d);
    div_valid = 1'b1; div_data = 28'(d);
    step();
    div_valid = 1'b0;
    checks++;
    if (div_active !== 28'(d)) begin errors++; $display("FAIL load_idle got=%0d exp=%0d", div_active, d); end
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks += 6;
      if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", div_ready); end
      if (tick !== 1'b0)      begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
      if (clk_out !== 1'b0)   begin errors++; $display("FAIL reset_clk got=%b exp=0", clk_out); end
      if (running !== 1'b0)   begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
      if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      if (div_active !== 28'd50000000) begin errors++; $display("FAIL reset_div got=%0d exp=50000000", div_active); end
      step();
    end
  endtask

  task automatic test_pattern(input int d);
    logic et, ec;
    do_reset(); load_idle(d); start_run();
    for (int c = 0; c < 3 * d; c++) begin
      et = ((c % d) == d - 1);
      ec = ((c % d) < d / 2);
      checks += 3;
      if (running !== 1'b1) begin errors++; $display("FAIL pat_running d=%0d c=%0d got=%b exp=1", d, c, running); end
      if (tick !== et)      begin errors++; $display("FAIL pat_tick d=%0d c=%0d got=%b exp=%b", d, c, tick, et); end
      if (clk_out !== ec)   begin errors++; $display("FAIL pat_clk d=%0d c=%0d got=%b exp=%b", d, c, clk_out, ec); end
      step();
    end
  endtask

  task automatic test_stop(input int d, input int s);
    int cs, cb;
    logic er, et, ec;
    do_reset(); load_idle(d); start_run();
    cs = d + s;
    cb = 2 * d - 1;
    for (int c = 0; c <= cb + 3; c++) begin
      er = (c <= cb);
      et = er && ((c % d) == d - 1);
      ec = er && ((c % d) < d / 2);
      checks += 3;
      if (running !== er) begin errors++; $display("FAIL stop_running d=%0d s=%0d c=%0d got=%b exp=%b", d, s, c, running, er); end
      if (tick !== et)    begin errors++; $display("FAIL stop_tick d=%0d s=%0d c=%0d got=%b exp=%b", d, s, c, tick, et); end
      if (clk_out !== ec) begin errors++; $display("FAIL stop_clk d=%0d s=%0d c=%0d got=%b exp=%b", d, s, c, clk_out, ec); end
      if (c == cs) stop = 1'b1;
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_drain_restart(input int d, input int cs, input int cr);
    logic et, ec;
    do_reset(); load_idle(d); start_run();
    for (int c = 0; c < 3 * d; c++) begin
      et = ((c % d) == d - 1);
      ec = ((c % d) < d / 2);
      checks += 3;
      if (running !== 1'b1) begin errors++; $display("FAIL drain_running d=%0d c=%0d got=%b exp=1", d, c, running); end
      if (tick !== et)      begin errors++; $display("FAIL drain_tick d=%0d c=%0d got=%b exp=%b", d, c, tick, et); end
      if (clk_out !== ec)   begin errors++; $display("FAIL drain_clk d=%0d c=%0d got=%b exp=%b", d, c, clk_out, ec); end
      if (c == cs) stop = 1'b1;
      if (c == cr) begin stop = 1'b0; start = 1'b1; end
      if (c == cr + 1) start = 1'b0;
      step();
    end
  endtask

  task automatic test_load_run(input int d0, input int d1, input int cl);
    int b, bp, dd, pos;
    logic et, ec, erdy;
    int ediv;
    do_reset(); load_idle(d0); start_run();
    b  = (cl / d0) * d0 + d0 - 1;
    bp = (cl == b) ? b + d0 : b;
    for (int c = 0; c <= bp + 2 * d1; c++) begin
      if (c <= bp) begin dd = d0; pos = c % d0; end
      else         begin dd = d1; pos = (c - bp - 1) % d1; end
      et   = (pos == dd - 1);
      ec   = (pos < dd / 2);
      erdy = !(c > cl && c <= bp);
      ediv = dd;
      checks += 4;
      if (tick !== et)       begin errors++; $display("FAIL ld_tick c=%0d got=%b exp=%b", c, tick, et); end
      if (clk_out !== ec)    begin errors++; $display("FAIL ld_clk c=%0d got=%b exp=%b", c, clk_out, ec); end
      if (div_ready !== erdy) begin errors++; $display("FAIL ld_ready c=%0d got=%b exp=%b", c, div_ready, erdy); end
      if (div_active !== 28'(ediv)) begin errors++; $display("FAIL ld_div c=%0d got=%0d exp=%0d", c, div_active, ediv); end
      if (c == cl)                 begin div_valid = 1'b1; div_data = 28'(d1); end
      else if (c > cl && c < bp)   begin div_valid = 1'b1; div_data = 28'd3; end
      else                         div_valid = 1'b0;
      step();
    end
    div_valid = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset(); load_idle(7);
    for (int k = 0; k < 2; k++) begin
      div_valid = 1'b1; div_data = (k == 0) ? 28'd1 : 28'd0;
      step();
      checks += 3;
      if (err !== 1'b1)        begin errors++; $display("FAIL ill_err k=%0d got=%b exp=1", k, err); end
      if (div_active !== 28'd7) begin errors++; $display("FAIL ill_div k=%0d got=%0d exp=7", k, div_active); end
      if (div_ready !== 1'b1)  begin errors++; $display("FAIL ill_ready k=%0d got=%b exp=1", k, div_ready); end
    end
    div_valid = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ill_clr got=%b exp=0", err); end
    div_valid = 1'b1; div_data = 28'd0; err_clr = 1'b1; step();
    div_valid = 1'b0; err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ill_set_wins got=%b exp=1", err); end
    step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ill_sticky got=%b exp=1", err); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    start_run();
    div_valid = 1'b1; div_data = 28'd1; step(); div_valid = 1'b0;
    checks += 4;
    if (err !== 1'b1)         begin errors++; $display("FAIL ill_run_err got=%b exp=1", err); end
    if (div_ready !== 1'b1)   begin errors++; $display("FAIL ill_run_ready got=%b exp=1", div_ready); end
    if (div_active !== 28'd7) begin errors++; $display("FAIL ill_run_div got=%0d exp=7", div_active); end
    if (running !== 1'b1)     begin errors++; $display("FAIL ill_run_running got=%b exp=1", running); end
  endtask

  task automatic test_reset_mid();
    do_reset(); load_idle(7); start_run();
    step();
    div_valid = 1'b1; div_data = 28'd0; step();
    div_data = 28'd3; step();
    div_valid = 1'b0;
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL mid_pending_ready got=%b exp=0", div_ready); end
    #2 reset = 1'b1;
    #1;
    checks += 6;
    if (running !== 1'b0)   begin errors++; $display("FAIL mid_running got=%b exp=0", running); end
    if (tick !== 1'b0)      begin errors++; $display("FAIL mid_tick got=%b exp=0", tick); end
    if (clk_out !== 1'b0)   begin errors++; $display("FAIL mid_clk got=%b exp=0", clk_out); end
    if (div_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", div_ready); end
    if (err !== 1'b0)       begin errors++; $display("FAIL mid_err got=%b exp=0", err); end
    if (div_active !== 28'd50000000) begin errors++; $display("FAIL mid_div got=%0d exp=50000000", div_active); end
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks += 3;
      if (running !== 1'b0) begin errors++; $display("FAIL post_running c=%0d got=%b exp=0", c, running); end
      if (tick !== 1'b0)    begin errors++; $display("FAIL post_tick c=%0d got=%b exp=0", c, tick); end
      if (div_active !== 28'd50000000) begin errors++; $display("FAIL post_div c=%0d got=%0d exp=50000000", c, div_active); end
    end
  endtask

  initial begin
    int d;
    test_reset();
    test_pattern(4);
    for (int i = 0; i < 3; i++) test_pattern($urandom_range(9, 2));
    test_load_run(4, 6, 1);
    test_load_run(4, 6, 3);
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(8, 2);
      test_load_run(d, $urandom_range(9, 4), $urandom_range(2 * d - 1, 0));
    end
    test_illegal();
    test_stop(5, 1);
    test_stop(5, 4);
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(9, 2);
      test_stop(d, $urandom_range(d - 1, 0));
    end
    test_drain_restart(5, 1, 2);
    for (int i = 0; i < 3; i++) test_drain_restart($urandom_range(9, 3), 0, 1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
